// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core: opcodes, funct3 codes, FSM states and ALU operations.
package cpu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // SUB only exists for register-register ops; bit 30 of an ADDI is immediate data.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                           input logic is_reg);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  if (is_reg && f7b5) op = ALU_SUB;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   if (f7b5) op = ALU_SRA; else op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU: add/sub, shifts (5-bit amount), signed/unsigned compares, logic ops.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << b_i[4:0];
            ALU_SLT:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: y_o = {31'b0, a_i < b_i};
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> b_i[4:0];
            ALU_SRA:  y_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Multi-cycle RV32I core (FETCH -> EXEC [-> MEM]); define CPU_RV32E_EN for a 16-entry register file.
// States: FETCH = latch instruction | EXEC = execute or form effective address | MEM = load/store access.
module cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] bus_addr,
    input  logic [31:0] bus_data_r,
    output logic [31:0] bus_data_w,
    output logic [3:0]  bus_mask_w,
    output logic        bus_write
);

`ifdef CPU_RV32E_EN
    localparam int NREG = 16;
    function automatic logic reg_ok(input logic [4:0] r);
        return (r != 5'd0) && !r[4];
    endfunction
`else
    localparam int NREG = 32;
    function automatic logic reg_ok(input logic [4:0] r);
        return r != 5'd0;
    endfunction
`endif
    localparam int RAW = $clog2(NREG);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, ea_q, ea_d;
    logic [31:0] rf_q [NREG];
    logic        rf_we;
    logic [31:0] rf_wd;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign funct3   = ir_q[14:12];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign rs1_val  = reg_ok(rs1) ? rf_q[rs1[RAW-1:0]] : '0;
    assign rs2_val  = reg_ok(rs2) ? rf_q[rs2[RAW-1:0]] : '0;
    assign pc_plus4 = pc_q + 32'd4;

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_y;
    assign alu_op = alu_decode(funct3, ir_q[30], opcode == OP_OP);
    assign alu_b  = (opcode == OP_OP) ? rs2_val : imm_i;

    cpu_alu u_alu (
        .op_i (alu_op),
        .a_i  (rs1_val),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    logic br_taken;
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = rs1_val == rs2_val;
            F3_BNE:  br_taken = rs1_val != rs2_val;
            F3_BLT:  br_taken = $signed(rs1_val) < $signed(rs2_val);
            F3_BGE:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            F3_BLTU: br_taken = rs1_val < rs2_val;
            F3_BGEU: br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    // Halfword lanes use ea[1] only, so misaligned accesses silently round down.
    logic [31:0] ld_b_sh, ld_h_sh, ld_val, st_data;
    logic [3:0]  st_mask;
    assign ld_b_sh = bus_data_r >> {ea_q[1:0], 3'b000};
    assign ld_h_sh = bus_data_r >> {ea_q[1], 4'b0000};

    always_comb begin
        ld_val = bus_data_r;
        case (funct3)
            F3_LB:   ld_val = {{24{ld_b_sh[7]}}, ld_b_sh[7:0]};
            F3_LH:   ld_val = {{16{ld_h_sh[15]}}, ld_h_sh[15:0]};
            F3_LBU:  ld_val = {24'b0, ld_b_sh[7:0]};
            F3_LHU:  ld_val = {16'b0, ld_h_sh[15:0]};
            default: ld_val = bus_data_r;
        endcase
    end

    always_comb begin
        st_mask = 4'b0000;
        st_data = '0;
        case (funct3)
            F3_SB: begin
                st_mask = 4'b0001 << ea_q[1:0];
                st_data = {24'b0, rs2_val[7:0]} << {ea_q[1:0], 3'b000};
            end
            F3_SH: begin
                st_mask = 4'b0011 << {ea_q[1], 1'b0};
                st_data = {16'b0, rs2_val[15:0]} << {ea_q[1], 4'b0000};
            end
            F3_SW: begin
                st_mask = 4'b1111;
                st_data = rs2_val;
            end
            default: begin
                st_mask = 4'b0000;
                st_data = '0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ea_d       = ea_q;
        rf_we      = 1'b0;
        rf_wd      = '0;
        bus_addr   = {2'b00, pc_q[31:2]};
        bus_write  = 1'b0;
        bus_mask_w = 4'b0000;
        bus_data_w = '0;
        case (state_q)
            FETCH: begin
                ir_d    = bus_data_r;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_plus4;
                case (opcode)
                    OP_LUI:   begin rf_we = 1'b1; rf_wd = imm_u; end
                    OP_AUIPC: begin rf_we = 1'b1; rf_wd = pc_q + imm_u; end
                    OP_JAL: begin
                        rf_we = 1'b1;
                        rf_wd = pc_plus4;
                        pc_d  = pc_q + imm_j;
                    end
                    OP_JALR: begin
                        rf_we = 1'b1;
                        rf_wd = pc_plus4;
                        pc_d  = (rs1_val + imm_i) & ~32'd1;
                    end
                    OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
                    OP_IMM, OP_OP: begin rf_we = 1'b1; rf_wd = alu_y; end
                    OP_LOAD: begin
                        ea_d    = rs1_val + imm_i;
                        pc_d    = pc_q;
                        state_d = MEM;
                    end
                    OP_STORE: begin
                        ea_d    = rs1_val + imm_s;
                        pc_d    = pc_q;
                        state_d = MEM;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                bus_addr = {2'b00, ea_q[31:2]};
                state_d  = FETCH;
                pc_d     = pc_plus4;
                if (opcode == OP_STORE) begin
                    if (!reset) begin
                        bus_write  = 1'b1;
                        bus_mask_w = st_mask;
                        bus_data_w = st_data;
                    end
                end else begin
                    rf_we = 1'b1;
                    rf_wd = ld_val;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ea_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ea_q    <= ea_d;
        end
    end

    always_ff @(posedge clock) begin
        if (rf_we && reg_ok(rd)) rf_q[rd[RAW-1:0]] <= rf_wd;
    end

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: directed programs push expected stores, a negedge monitor checks them.
module tb_cpu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_addr, bus_data_r, bus_data_w;
    logic [3:0]  bus_mask_w;
    logic        bus_write;

    cpu dut (
        .clock      (clock),
        .reset      (reset),
        .bus_addr   (bus_addr),
        .bus_data_r (bus_data_r),
        .bus_data_w (bus_data_w),
        .bus_mask_w (bus_mask_w),
        .bus_write  (bus_write)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [64];
    assign bus_data_r = mem[bus_addr[5:0]];

    always @(posedge clock) begin
        if (bus_write)
            for (int b = 0; b < 4; b++)
                if (bus_mask_w[b]) mem[bus_addr[5:0]][8*b +: 8] = bus_data_w[8*b +: 8];
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } st_t;

    st_t exp_q[$];
    st_t mon_e;
    int  checks = 0;
    int  failures = 0;
    int  wr_seen = 0;
    int  wr_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && bus_write) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_store actual addr=%h data=%h required=no store",
                         bus_addr, bus_data_w);
            end else begin
                mon_e = exp_q.pop_front();
                check("store_addr", bus_addr, mon_e.addr);
                check("store_mask", {28'b0, bus_mask_w}, {28'b0, mon_e.mask});
                check("store_data", bus_data_w, mon_e.data);
            end
        end
    end

    task automatic exp_st(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        exp_q.push_back('{addr: a, mask: m, data: d});
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual pending=%0d required=0", name, exp_q.size());
        end
        repeat (12) @(posedge clock);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] u_t(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), op};
    endfunction

    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
    endfunction

    localparam logic [6:0] OPI = 7'h13, OPL = 7'h03, OPLUI = 7'h37, OPAU = 7'h17, OPJR = 7'h67;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Phase A: ALU ops, stores, sub-word store lanes.
        clear_mem();
        mem[0]  = i_t(5, 0, 0, 1, OPI);
        mem[1]  = s_t(40, 1, 0, 2);
        mem[2]  = i_t(32'h55, 0, 0, 1, OPI);
        mem[3]  = s_t(32, 1, 0, 2);
        mem[4]  = i_t(32'hAB, 0, 0, 1, OPI);
        mem[5]  = s_t(32'h21, 1, 0, 0);
        mem[6]  = u_t(32'h80000, 2, OPLUI);
        mem[7]  = j_t(36, 5);
        mem[16] = s_t(44, 5, 0, 2);
        mem[17] = i_t(32'h404, 2, 5, 3, OPI);
        mem[18] = s_t(48, 3, 0, 2);
        mem[19] = r_t(32, 1, 0, 0, 4);
        mem[20] = s_t(32'h36, 4, 0, 1);
        mem[21] = r_t(0, 1, 2, 2, 6);
        mem[22] = r_t(0, 1, 2, 3, 7);
        mem[23] = s_t(56, 6, 0, 2);
        mem[24] = s_t(60, 7, 0, 2);
        mem[25] = i_t(32'hFF, 1, 4, 9, OPI);
        mem[26] = r_t(0, 1, 2, 5, 10);
        mem[27] = r_t(0, 10, 9, 6, 11);
        mem[28] = s_t(64, 11, 0, 2);
        mem[29] = j_t(0, 0);
        exp_st(32'd10, 4'hF, 32'h0000_0005);
        exp_st(32'd8,  4'hF, 32'h0000_0055);
        exp_st(32'd8,  4'b0010, 32'h0000_AB00);
        exp_st(32'd11, 4'hF, 32'h0000_0020);
        exp_st(32'd12, 4'hF, 32'hF800_0000);
        exp_st(32'd13, 4'b1100, 32'hFF55_0000);
        exp_st(32'd14, 4'hF, 32'h0000_0001);
        exp_st(32'd15, 4'hF, 32'h0000_0000);
        exp_st(32'd16, 4'hF, 32'h0010_0054);
        #12;
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_write", {31'b0, bus_write}, 32'h0);
        check("rst_bus_mask", {28'b0, bus_mask_w}, 32'h0);
        check("rst_bus_data", bus_data_w, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 check("second_fetch_addr", bus_addr, 32'h1);
        drain(400, "phase_a");
        check("mem_word8", mem[8], 32'h0000_AB55);

        // Phase B: loads with extension, branches, jalr, NOPs, x0.
        @(negedge clock);
        reset = 1'b1;
        clear_mem();
        mem[8]  = 32'h0000_80FF;
        mem[0]  = i_t(32, 0, 0, 2, OPL);
        mem[1]  = i_t(32, 0, 5, 3, OPL);
        mem[2]  = s_t(40, 2, 0, 2);
        mem[3]  = s_t(44, 3, 0, 2);
        mem[4]  = i_t(33, 0, 1, 4, OPL);
        mem[5]  = s_t(48, 4, 0, 2);
        mem[6]  = i_t(33, 0, 4, 5, OPL);
        mem[7]  = j_t(36, 0);
        mem[16] = s_t(52, 5, 0, 2);
        mem[17] = b_t(8, 0, 5, 0);
        mem[18] = i_t(7, 0, 0, 6, OPI);
        mem[19] = b_t(8, 0, 5, 1);
        mem[20] = i_t(99, 0, 0, 6, OPI);
        mem[21] = s_t(56, 6, 0, 2);
        mem[22] = u_t(0, 7, OPAU);
        mem[23] = i_t(13, 7, 0, 8, OPJR);
        mem[24] = s_t(0, 0, 0, 2);
        mem[25] = s_t(60, 8, 0, 2);
        mem[26] = 32'h0000_0073;
        mem[27] = i_t(1, 0, 0, 0, OPI);
        mem[28] = s_t(64, 0, 0, 2);
        mem[29] = j_t(0, 0);
        exp_st(32'd10, 4'hF, 32'hFFFF_FFFF);
        exp_st(32'd11, 4'hF, 32'h0000_80FF);
        exp_st(32'd12, 4'hF, 32'hFFFF_80FF);
        exp_st(32'd13, 4'hF, 32'h0000_0080);
        exp_st(32'd14, 4'hF, 32'h0000_0007);
        exp_st(32'd15, 4'hF, 32'h0000_0060);
        exp_st(32'd16, 4'hF, 32'h0000_0000);
        @(negedge clock);
        reset = 1'b0;
        drain(400, "phase_b");

        // Phase C: backward branch loop, no bus writes.
        @(negedge clock);
        reset = 1'b1;
        clear_mem();
        mem[0] = i_t(0, 0, 0, 1, OPI);
        mem[1] = i_t(1, 1, 0, 1, OPI);
        mem[2] = b_t(-4, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        wr_base = wr_seen;
        repeat (4) @(posedge clock);
        #1 check("fetch_pc8", bus_addr, 32'h2);
        repeat (2) @(posedge clock);
        #1 check("branch_target_pc4", bus_addr, 32'h1);
        repeat (20) @(posedge clock);
        check("branch_no_write", wr_seen - wr_base, 32'h0);

        // Phase D: reset asserted during a store's MEM cycle.
        @(negedge clock);
        reset = 1'b1;
        clear_mem();
        mem[0] = i_t(32'h3C, 0, 0, 1, OPI);
        mem[1] = s_t(40, 1, 0, 2);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("midstore_write", {31'b0, bus_write}, 32'h1);
        check("midstore_addr", bus_addr, 32'd10);
        check("midstore_data", bus_data_w, 32'h0000_003C);
        #1 reset = 1'b1;
        #1;
        check("abort_write", {31'b0, bus_write}, 32'h0);
        check("abort_mask", {28'b0, bus_mask_w}, 32'h0);
        check("abort_data", bus_data_w, 32'h0);
        check("abort_addr", bus_addr, 32'h0);
        @(negedge clock);
        @(negedge clock);
        check("abort_mem10", mem[10], 32'h0);
        reset = 1'b0;
        #1 check("refetch_addr", bus_addr, 32'h0);
        repeat (2) @(posedge clock);
        #1 check("refetch_next_addr", bus_addr, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
